// File: rtl/spi_pix_pkg.sv
// Shared opcodes, FSM state encoding and pixel word type for the SPI pixel frame path.
// No logic; constants and types only.
// No flow control.
package spi_pix_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_SHOW   = 8'h02;
  localparam logic [7:0] CMD_BRIGHT = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IDX,
    ST_CNT,
    ST_PG,
    ST_PR,
    ST_PB,
    ST_BRT,
    ST_DRAIN
  } state_t;

  // Pixel word as stored in the pixel RAM, G in the top byte.
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;

endpackage

// File: rtl/pix_refresh_sched.sv
// Holds a pending refresh request and issues it to the driver when the driver is idle.
// Latency: a request set at edge N can start a refresh in the cycle right after N.
// Backpressure: requests arriving while busy or already pending collapse into one.
module pix_refresh_sched (
  input  logic clk,
  input  logic rst,
  input  logic i_show_set,
  input  logic i_refresh_busy,
  output logic o_refresh_start
);

  logic r_show_pend;
  logic w_fire;

  // Start is issued in the first idle cycle, so it tracks busy combinationally.
  assign w_fire          = r_show_pend & ~i_refresh_busy;
  assign o_refresh_start = w_fire;

  // Pending flag: a new request wins over the clear so a SHOW landing on the
  // firing cycle still produces a later refresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_show_pend <= 1'b0;
    end else if (i_show_set) begin
      r_show_pend <= 1'b1;
    end else if (w_fire) begin
      r_show_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_pixel_frame_ctrl.sv
// Parses SPI byte frames into pixel RAM writes, brightness updates and refresh requests.
// Latency: pix_we one cycle after the B byte; brightness one cycle after its byte.
// Backpressure: none, one byte per cycle; optional AUTO_SHOW_EN makes a finished WRITE request a refresh.
module spi_pixel_frame_ctrl
  import spi_pix_pkg::*;
#(
  parameter int         NUM_PIXELS = 60,
  parameter int         ADDR_W     = 8,
  parameter logic [7:0] BRIGHT_RST = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              cs_active,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [23:0]       pix_wdata,
  output logic [7:0]        brightness,
  input  logic              refresh_busy,
  output logic              refresh_start,
  output logic              err_cmd,
  output logic              err_ovr
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_cnt;
  logic [7:0]        r_g;
  logic [7:0]        r_r;
  logic              r_pix_we;
  logic [ADDR_W-1:0] r_pix_addr;
  pixel_t            r_pix_wdata;
  logic [7:0]        r_brightness;
  logic              r_err_cmd;
  logic              r_err_ovr;

  logic w_take;
  logic w_addr_ok;
  logic w_last;
  logic w_show_set;

  // A byte is only consumed while the frame is open.
  assign w_take    = rx_ready & cs_active;
  assign w_addr_ok = (int'(r_addr) < NUM_PIXELS);
  // Count of 0 stands for 256, so the last pixel is the one seen with count 1.
  assign w_last    = (r_cnt == 8'd1);

`ifdef AUTO_SHOW_EN
  assign w_show_set = w_take && (((r_state == ST_IDLE) && (rx_data == CMD_SHOW)) ||
                                 ((r_state == ST_PB) && w_last));
`else
  assign w_show_set = w_take && (r_state == ST_IDLE) && (rx_data == CMD_SHOW);
`endif

  // Command FSM with address/count tracking, pixel assembly and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_g          <= '0;
      r_r          <= '0;
      r_pix_we     <= 1'b0;
      r_pix_addr   <= '0;
      r_pix_wdata  <= '0;
      r_brightness <= BRIGHT_RST;
      r_err_cmd    <= 1'b0;
      r_err_ovr    <= 1'b0;
    end else begin
      r_pix_we <= 1'b0;
      if (!cs_active) begin
        // Frame closed: abandon any half-built command or pixel.
        r_state <= ST_IDLE;
      end else if (rx_ready) begin
        case (r_state)
          ST_IDLE: begin
            case (rx_data)
              CMD_WRITE:  r_state <= ST_IDX;
              CMD_SHOW:   r_state <= ST_DRAIN;
              CMD_BRIGHT: r_state <= ST_BRT;
              default: begin
                r_err_cmd <= 1'b1;
                r_state   <= ST_DRAIN;
              end
            endcase
          end
          ST_IDX: begin
            r_addr  <= ADDR_W'(rx_data);
            r_state <= ST_CNT;
          end
          ST_CNT: begin
            r_cnt   <= rx_data;
            r_state <= ST_PG;
          end
          ST_PG: begin
            r_g     <= rx_data;
            r_state <= ST_PR;
          end
          ST_PR: begin
            r_r     <= rx_data;
            r_state <= ST_PB;
          end
          ST_PB: begin
            if (w_addr_ok) begin
              r_pix_we    <= 1'b1;
              r_pix_addr  <= r_addr;
              r_pix_wdata <= '{g: r_g, r: r_r, b: rx_data};
            end else begin
              r_err_ovr <= 1'b1;
            end
            r_addr  <= r_addr + 1'b1;
            r_cnt   <= r_cnt - 8'd1;
            r_state <= w_last ? ST_IDLE : ST_PG;
          end
          ST_BRT: begin
            r_brightness <= rx_data;
            r_state      <= ST_DRAIN;
          end
          ST_DRAIN: r_state <= ST_DRAIN;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

  pix_refresh_sched u_sched (
    .clk             (clk),
    .rst             (rst),
    .i_show_set      (w_show_set),
    .i_refresh_busy  (refresh_busy),
    .o_refresh_start (refresh_start)
  );

  assign pix_we     = r_pix_we;
  assign pix_addr   = r_pix_addr;
  assign pix_wdata  = r_pix_wdata;
  assign brightness = r_brightness;
  assign err_cmd    = r_err_cmd;
  assign err_ovr    = r_err_ovr;

endmodule
